if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a prefetch buffer, placed between the instruction RAM port and the ID stage. It issues sequential fetch requests over the split address/data (`addr_ok`/`data_ok`) handshake, keeps up to `MAX_OUTSTANDING` requests in flight, and buffers returned instructions in a `DEPTH`-entry in-order queue. It presents the buffered instructions to ID over valid/ready. On a redirect it flushes the queue, discards stale in-flight responses and restarts fetch at the new PC.

---
 rtl/if_prefetch.sv | 148 ++++++++++++++
 tb/tb_if_prefetch.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: issues sequential fetches over a split addr_ok/data_ok
// port, buffers replies in an in-order prefetch queue and hands them to ID.
module if_prefetch #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic              clk,
  input  logic              rst_b,
  output logic              iram_req,
  output logic              iram_write,
  output logic [XLEN/8-1:0] iram_wstrb,
  output logic [XLEN-1:0]   iram_addr,
  output logic [XLEN-1:0]   iram_wdata,
  input  logic              iram_addr_ok,
  input  logic              iram_data_ok,
  input  logic [XLEN-1:0]   iram_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              id_pipe_valid,
  input  logic              id_pipe_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   id_instruction
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam sum_t MAX_C   = sum_t'(MAX_OUTSTANDING);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  ptr_t             alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  cnt_t             count_q, count_d;
  cnt_t             inflight_q, inflight_d;
  cnt_t             drop_q, drop_d;

  logic hs, fill_en, drop_en, pop;
  sum_t outstanding, drop_redir;
  logic unused_pc_lsbs;

  assign iram_write      = 1'b0;
  assign iram_wstrb      = '0;
  assign iram_wdata      = '0;
  assign iram_addr       = fetch_pc_q;
  assign unused_pc_lsbs  = ^redirect_pc[1:0];

  // Issue gate looks at registered state only; stale responses still occupy the port.
  assign outstanding = sum_t'(inflight_q) + sum_t'(drop_q);
  assign iram_req    = rst_b && (count_q < DEPTH_C) && (outstanding < MAX_C);
  assign hs          = iram_req && iram_addr_ok;

  assign drop_en = iram_data_ok && (drop_q != '0);
  assign fill_en = iram_data_ok && (drop_q == '0);

  assign id_pipe_valid  = filled_q[head_q] && !redirect_valid;
  assign pop            = id_pipe_valid && id_pipe_ready;
  assign id_pc          = ent_q[head_q].pc;
  assign id_instruction = ent_q[head_q].data;

  // Everything the port owes us after a redirect becomes a response to throw away.
  assign drop_redir = sum_t'(drop_q) + sum_t'(inflight_q) + sum_t'(hs) - sum_t'(iram_data_ok);

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one unassigned
    // and infer a latch.
    fetch_pc_d = fetch_pc_q;
    ent_d      = ent_q;
    filled_d   = filled_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      filled_d   = '0;
      count_d    = '0;
      inflight_d = '0;
      drop_d     = cnt_t'(drop_redir);
    end else begin
      if (hs) begin
        ent_d[alloc_q].pc = fetch_pc_q;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + ptr_t'(1);
        fetch_pc_d        = fetch_pc_q + XLEN'(4);
      end
      if (fill_en) begin
        ent_d[fill_q].data = iram_rdata;
        filled_d[fill_q]   = 1'b1;
        fill_d             = fill_q + ptr_t'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + ptr_t'(1);
      end
      if (drop_en) drop_d = drop_q - cnt_t'(1);
      count_d    = count_q + cnt_t'(hs) - cnt_t'(pop);
      inflight_d = inflight_q + cnt_t'(hs) - cnt_t'(fill_en);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fetch_pc_q <= RESET_PC;
      // NOTE: the queue storage is reset too because ID sees the head entry directly
      // and must read pc/instruction as zero out of reset; it is only DEPTH words.
      ent_q      <= '{default: '0};
      filled_q   <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the same pre-edge values.
      fetch_pc_q <= fetch_pc_d;
      ent_q      <= ent_d;
      filled_q   <= filled_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a memory model with random wait states feeds the DUT and a
// stream-level scoreboard checks fetch addresses, ID ordering and redirect behaviour.
module tb_if_prefetch;

  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        iram_req, iram_write;
  logic [3:0]  iram_wstrb;
  logic [31:0] iram_addr, iram_wdata;
  logic        iram_addr_ok, iram_data_ok;
  logic [31:0] iram_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_pipe_valid, id_pipe_ready;
  logic [31:0] id_pc, id_instruction;

  if_prefetch #(
    .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
    .iram_addr(iram_addr), .iram_wdata(iram_wdata),
    .iram_addr_ok(iram_addr_ok), .iram_data_ok(iram_data_ok), .iram_rdata(iram_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_pipe_valid(id_pipe_valid), .id_pipe_ready(id_pipe_ready),
    .id_pc(id_pc), .id_instruction(id_instruction)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  int aok_pct, dok_pct, rdy_pct;
  logic        redir_req;
  logic [31:0] redir_target;

  logic [31:0] pending[$];
  logic [31:0] exp_pc, exp_fetch;
  int          hs_count, pop_count;
  logic [31:0] last_hs_addr, last_pop_pc;
  logic        last_hs, last_dok;
  logic        stall_prev, hold_prev;
  logic [31:0] stall_addr, hold_pc, hold_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int pick_pct();
    case ($urandom_range(2))
      0:       return 100;
      1:       return 60;
      default: return 25;
    endcase
  endfunction

  // One clock: drive memory/ID/redirect inputs after the edge, observe on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    iram_addr_ok = ($urandom_range(99) < aok_pct);
    if (pending.size() > 0 && $urandom_range(99) < dok_pct) begin
      iram_data_ok = 1'b1;
      iram_rdata   = mem_word(pending[0]);
    end else begin
      iram_data_ok = 1'b0;
      iram_rdata   = $urandom;
    end
    redirect_valid = redir_req;
    redirect_pc    = redir_req ? redir_target : $urandom;
    redir_req      = 1'b0;
    id_pipe_ready  = ($urandom_range(99) < rdy_pct);
    @(negedge clk);

    if (stall_prev) begin
      tests_run++;
      if (iram_req !== 1'b1 || iram_addr !== stall_addr) begin
        tests_failed++;
        $display("FAIL addr_hold: req=%0b addr=%h, required req=1 addr=%h", iram_req, iram_addr, stall_addr);
      end
    end
    if (hold_prev && !redirect_valid) begin
      tests_run++;
      if (id_pipe_valid !== 1'b1 || id_pc !== hold_pc || id_instruction !== hold_instr) begin
        tests_failed++;
        $display("FAIL id_hold: valid=%0b pc=%h instr=%h, required 1 %h %h", id_pipe_valid, id_pc, id_instruction, hold_pc, hold_instr);
      end
    end

    last_hs  = iram_req && iram_addr_ok;
    last_dok = iram_data_ok;
    if (last_hs) begin
      tests_run++;
      if (iram_addr !== exp_fetch) begin
        tests_failed++;
        $display("FAIL fetch_addr: got %h, required %h", iram_addr, exp_fetch);
      end
      tests_run++;
      if (pending.size() >= MAX_OUT) begin
        tests_failed++;
        $display("FAIL outstanding: %0d already open at accept, required < %0d", pending.size(), MAX_OUT);
      end
      pending.push_back(iram_addr);
      hs_count++;
      last_hs_addr = iram_addr;
    end
    if (iram_data_ok) void'(pending.pop_front());

    if (redirect_valid) begin
      tests_run++;
      if (id_pipe_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL redirect_valid_gate: id_pipe_valid=%0b, required 0", id_pipe_valid);
      end
    end else if (id_pipe_valid === 1'b1 && id_pipe_ready) begin
      tests_run++;
      if (id_pc !== exp_pc || id_instruction !== mem_word(exp_pc)) begin
        tests_failed++;
        $display("FAIL id_stream: pc=%h instr=%h, required pc=%h instr=%h", id_pc, id_instruction, exp_pc, mem_word(exp_pc));
      end
      pop_count++;
      last_pop_pc = id_pc;
      exp_pc += 32'd4;
    end

    if (redirect_valid) begin
      exp_pc    = {redirect_pc[31:2], 2'b00};
      exp_fetch = exp_pc;
    end else if (last_hs) begin
      exp_fetch += 32'd4;
    end

    stall_prev = iram_req && !iram_addr_ok && !redirect_valid;
    stall_addr = iram_addr;
    hold_prev  = id_pipe_valid && !id_pipe_ready;
    hold_pc    = id_pc;
    hold_instr = id_instruction;
  endtask

  task automatic clear_model();
    pending.delete();
    exp_pc     = RESET_PC;
    exp_fetch  = RESET_PC;
    stall_prev = 1'b0;
    hold_prev  = 1'b0;
    redir_req  = 1'b0;
  endtask

  task automatic do_reset();
    aok_pct = 0; dok_pct = 0; rdy_pct = 0;
    iram_addr_ok = 1'b0; iram_data_ok = 1'b0; id_pipe_ready = 1'b0; redirect_valid = 1'b0;
    rst_b = 1'b0;
    #1;
    tests_run++;
    if (iram_req !== 1'b0 || id_pipe_valid !== 1'b0 || id_pc !== 32'h0 ||
        id_instruction !== 32'h0 || iram_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL async_reset: req=%0b valid=%0b pc=%h instr=%h addr=%h, required 0 0 0 0 %h",
               iram_req, id_pipe_valid, id_pc, id_instruction, iram_addr, RESET_PC);
    end
    clear_model();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    iram_addr_ok = 1'b0; iram_data_ok = 1'b0; iram_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_pipe_ready = 1'b0;
    hs_count = 0; pop_count = 0;
    clear_model();
    #12;
    tests_run++;
    if (iram_req !== 1'b0 || iram_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL reset_fetch: req=%0b addr=%h, required 0 %h", iram_req, iram_addr, RESET_PC);
    end
    tests_run++;
    if ({iram_write, iram_wstrb, iram_wdata} !== 37'h0) begin
      tests_failed++;
      $display("FAIL reset_tieoff: write=%0b wstrb=%h wdata=%h, required all 0", iram_write, iram_wstrb, iram_wdata);
    end
    tests_run++;
    if (id_pipe_valid !== 1'b0 || id_pc !== 32'h0 || id_instruction !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_id: valid=%0b pc=%h instr=%h, required 0 0 0", id_pipe_valid, id_pc, id_instruction);
    end
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    tests_run++;
    if (iram_req !== 1'b1 || iram_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL first_request: req=%0b addr=%h, required 1 %h", iram_req, iram_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    int h0, p0;
    aok_pct = 100; dok_pct = 100; rdy_pct = 100;
    h0 = hs_count; p0 = pop_count;
    repeat (10) cycle();
    tests_run++;
    if (hs_count - h0 != 10 || pop_count - p0 != 8) begin
      tests_failed++;
      $display("FAIL throughput: %0d accepts %0d pops, required 10 accepts 8 pops", hs_count - h0, pop_count - p0);
    end
  endtask

  task automatic test_addr_wait();
    int h0;
    do_reset();
    aok_pct = 0; dok_pct = 100; rdy_pct = 100;
    h0 = hs_count;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (iram_req !== 1'b1 || iram_addr !== RESET_PC) begin
        tests_failed++;
        $display("FAIL wait_state_%0d: req=%0b addr=%h, required 1 %h", i, iram_req, iram_addr, RESET_PC);
      end
    end
    aok_pct = 100;
    cycle();
    aok_pct = 0;
    tests_run++;
    if (hs_count - h0 != 1 || last_hs_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL wait_accept: %0d accepts addr=%h, required 1 at %h", hs_count - h0, last_hs_addr, RESET_PC);
    end
  endtask

  task automatic test_backpressure();
    int h0, p0, n;
    do_reset();
    aok_pct = 100; dok_pct = 100; rdy_pct = 0;
    h0 = hs_count;
    repeat (8) cycle();
    tests_run++;
    if (hs_count - h0 != 4 || iram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL queue_full: %0d accepts req=%0b, required 4 accepts req=0", hs_count - h0, iram_req);
    end
    tests_run++;
    if (id_pipe_valid !== 1'b1 || id_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL full_head: valid=%0b pc=%h, required 1 00000000", id_pipe_valid, id_pc);
    end
    rdy_pct = 100;
    h0 = hs_count; p0 = pop_count; n = 0;
    while (hs_count == h0 && n < 12) begin cycle(); n++; end
    tests_run++;
    if (hs_count == h0 || last_hs_addr !== 32'h10) begin
      tests_failed++;
      $display("FAIL resume_issue: accepts=%0d addr=%h, required first accept at 00000010", hs_count - h0, last_hs_addr);
    end
    repeat (4) cycle();
    tests_run++;
    if (pop_count - p0 < 4) begin
      tests_failed++;
      $display("FAIL drain: %0d pops, required at least 4", pop_count - p0);
    end
  endtask

  task automatic test_redirect_inflight();
    int h0, p0, n;
    do_reset();
    rdy_pct = 100;
    h0 = hs_count;
    aok_pct = 100; dok_pct = 0;   repeat (2) cycle();
    aok_pct = 0;   dok_pct = 100; repeat (2) cycle();
    aok_pct = 100; dok_pct = 0;   repeat (3) cycle();
    tests_run++;
    if (hs_count - h0 != 4 || last_hs_addr !== 32'hC) begin
      tests_failed++;
      $display("FAIL inflight_setup: %0d accepts last=%h, required 4 last=0000000c", hs_count - h0, last_hs_addr);
    end
    aok_pct = 0;
    redir_req = 1'b1; redir_target = 32'h100;
    cycle();
    aok_pct = 100; dok_pct = 100;
    cycle();
    tests_run++;
    if (iram_addr !== 32'h100 || iram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL redirect_target: addr=%h req=%0b, required 00000100 req=0 (two stale open)", iram_addr, iram_req);
    end
    p0 = pop_count; n = 0;
    while (pop_count == p0 && n < 20) begin cycle(); n++; end
    tests_run++;
    if (pop_count == p0 || last_pop_pc !== 32'h100) begin
      tests_failed++;
      $display("FAIL redirect_first_pc: pops=%0d pc=%h, required first pc 00000100", pop_count - p0, last_pop_pc);
    end
  endtask

  task automatic test_redirect_coincident();
    int p0, n;
    do_reset();
    aok_pct = 100; dok_pct = 100; rdy_pct = 100;
    repeat (5) cycle();
    redir_req = 1'b1; redir_target = 32'h2000;
    cycle();
    tests_run++;
    if (!(last_hs && last_dok)) begin
      tests_failed++;
      $display("FAIL coincident_setup: accept=%0b data_ok=%0b in redirect cycle, required 1 1", last_hs, last_dok);
    end
    p0 = pop_count; n = 0;
    while (pop_count == p0 && n < 20) begin cycle(); n++; end
    tests_run++;
    if (pop_count == p0 || last_pop_pc !== 32'h2000) begin
      tests_failed++;
      $display("FAIL coincident_first_pc: pops=%0d pc=%h, required 00002000", pop_count - p0, last_pop_pc);
    end
    redir_req = 1'b1; redir_target = 32'h3000;
    cycle();
    redir_req = 1'b1; redir_target = 32'h4003;
    cycle();
    p0 = pop_count; n = 0;
    while (pop_count == p0 && n < 20) begin cycle(); n++; end
    tests_run++;
    if (pop_count == p0 || last_pop_pc !== 32'h4000) begin
      tests_failed++;
      $display("FAIL back_to_back_redirect: pops=%0d pc=%h, required 00004000", pop_count - p0, last_pop_pc);
    end
  endtask

  task automatic test_outstanding_limit();
    int h0;
    do_reset();
    aok_pct = 100; dok_pct = 0; rdy_pct = 100;
    h0 = hs_count;
    repeat (6) cycle();
    tests_run++;
    if (hs_count - h0 != 2 || iram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL outstanding_limit: %0d accepts req=%0b, required 2 req=0", hs_count - h0, iram_req);
    end
    aok_pct = 0; dok_pct = 100;
    cycle();
    dok_pct = 0;
    cycle();
    tests_run++;
    if (iram_req !== 1'b1 || iram_addr !== 32'h8) begin
      tests_failed++;
      $display("FAIL limit_release: req=%0b addr=%h, required 1 00000008", iram_req, iram_addr);
    end
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    p0 = pop_count;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (i % 64 == 0 || i == 1500) begin
        aok_pct = pick_pct(); dok_pct = pick_pct(); rdy_pct = pick_pct();
      end
      if ($urandom_range(99) < 3) begin
        redir_req    = 1'b1;
        redir_target = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
      end
      cycle();
    end
    tests_run++;
    if (pop_count - p0 < 100) begin
      tests_failed++;
      $display("FAIL random_progress: %0d instructions delivered, required at least 100", pop_count - p0);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_addr_wait();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_outstanding_limit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
